start_pulse_gen: RTL and testbench

Parametrised multi-channel start/trigger generator for the front-end timing path. A prescaled timebase produces start events every `user_period` ticks. Events run free, in counted bursts, or as one-shots. Each event is fanned out to `NUM_CH` outputs, and each output has its own delay and a programmable pulse width. Status outputs report activity, dropped events and the number of events issued.

---
 rtl/start_gen_pkg.sv | 23 ++
 rtl/start_pulse_channel.sv | 82 ++++++++
 rtl/start_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_start_pulse_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/start_gen_pkg.sv
// Shared encodings and widths for the start/trigger generator.
package start_gen_pkg;
  localparam int START_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'b00,
    MODE_BURST    = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_IDLE     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_PULSE = 2'd2
  } ch_state_t;
endpackage

// File: rtl/start_pulse_channel.sv
// One output channel: delays an event by `delay` cycles, then drives a pulse of max(width,1) cycles.
// Events arriving while delaying or pulsing are dropped and reported on `drop`.
module start_pulse_channel
  import start_gen_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int PW_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fire,
  input  logic [DLY_W-1:0] delay,
  input  logic [PW_W-1:0]  width,
  output logic             out,
  output logic             busy,
  output logic             drop
);
  ch_state_t        state, state_nxt;
  logic [DLY_W-1:0] dly_cnt, dly_nxt;
  logic [PW_W-1:0]  wid_cnt, wid_nxt;
  logic [PW_W-1:0]  wid_load;

  // Width counter holds remaining high cycles minus one; zero width acts as one.
  assign wid_load = (width == '0) ? '0 : width - PW_W'(1);

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    wid_nxt   = wid_cnt;
    drop      = 1'b0;
    case (state)
      CH_IDLE: begin
        if (fire) begin
          if (delay == '0) begin
            state_nxt = CH_PULSE;
            wid_nxt   = wid_load;
          end else begin
            state_nxt = CH_DELAY;
            dly_nxt   = delay;
          end
        end
      end
      CH_DELAY: begin
        drop = fire;
        if (dly_cnt == DLY_W'(1)) begin
          state_nxt = CH_PULSE;
          wid_nxt   = wid_load;
        end else begin
          dly_nxt = dly_cnt - DLY_W'(1);
        end
      end
      CH_PULSE: begin
        drop = fire;
        if (wid_cnt == '0) state_nxt = CH_IDLE;
        else               wid_nxt   = wid_cnt - PW_W'(1);
      end
      default: state_nxt = CH_IDLE;
    endcase
    if (clr) begin
      state_nxt = CH_IDLE;
      dly_nxt   = '0;
      wid_nxt   = '0;
      drop      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CH_IDLE;
      dly_cnt <= '0;
      wid_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
      wid_cnt <= wid_nxt;
    end
  end

  assign out  = (state == CH_PULSE);
  assign busy = (state != CH_IDLE);
endmodule

// File: rtl/start_pulse_gen.sv
// Multi-channel start generator: prescaled timebase, periodic/burst/one-shot sequencer, per-channel delay+width.
// Optional START_GEN_EXT_SYNC_EN adds an ext_sync input whose rising edge realigns the timebase while running.
module start_pulse_gen
  import start_gen_pkg::*;
#(
  parameter int PRESCALE_W = 23,
  parameter int PERIOD_W   = 8,
  parameter int NUM_CH     = 4,
  parameter int DLY_W      = 8,
  parameter int PW_W       = 4,
  parameter int BURST_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic [PERIOD_W-1:0]     user_period,
  input  logic [BURST_W-1:0]      burst_count,
  input  logic [PW_W-1:0]         pulse_width,
  input  logic [NUM_CH*DLY_W-1:0] ch_delay,
`ifdef START_GEN_EXT_SYNC_EN
  input  logic                    ext_sync,
`endif
  output logic [NUM_CH-1:0]       out_start,
  output logic                    busy,
  output logic                    overrun,
  output logic [START_CNT_W-1:0]  start_count
);
  seq_state_t          state, state_nxt;
  mode_t               mode_q, mode_eff;
  logic                en_q, launch, tick, ev, sync_rise, clr;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PERIOD_W-1:0] per_cnt, period_q;
  logic [BURST_W-1:0]  n_q, ev_cnt;
  logic [NUM_CH-1:0]   ch_busy, ch_drop;

  // On the first enabled edge mode_q is not yet loaded, so look at the live input.
  assign mode_eff = en_q ? mode_q : mode_t'(mode);
  assign clr      = !enable;
  assign tick     = &pre_cnt;
  assign ev       = enable && (state == ST_RUN) && tick && (period_q != '0) &&
                    (per_cnt == period_q - PERIOD_W'(1)) && !sync_rise;

`ifdef START_GEN_EXT_SYNC_EN
  logic sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 1'b0;
    else        sync_q <= ext_sync;
  end
  assign sync_rise = ext_sync && !sync_q && (state == ST_RUN);
`else
  assign sync_rise = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        case (mode_eff)
          MODE_PERIODIC: launch = 1'b1;
          MODE_BURST:    launch = arm && (burst_count != '0);
          MODE_ONESHOT:  launch = arm;
          default:       launch = 1'b0;
        endcase
      end
      ST_RUN: begin
        if (ev && (mode_q != MODE_PERIODIC) && (ev_cnt == n_q - BURST_W'(1)))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ch_busy == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (launch) state_nxt = ST_RUN;
    if (!enable) begin
      state_nxt = ST_IDLE;
      launch    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      en_q        <= 1'b0;
      mode_q      <= MODE_PERIODIC;
      pre_cnt     <= '0;
      per_cnt     <= '0;
      period_q    <= '0;
      n_q         <= '0;
      ev_cnt      <= '0;
      overrun     <= 1'b0;
      start_count <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= enable;
      if (enable && !en_q) mode_q <= mode_t'(mode);
      if (!enable) begin
        pre_cnt <= '0;
        per_cnt <= '0;
        ev_cnt  <= '0;
        overrun <= 1'b0;
      end else begin
        if (launch) begin
          // The launch edge itself is the first prescaler cycle of the run.
          pre_cnt  <= PRESCALE_W'(1);
          per_cnt  <= '0;
          period_q <= user_period;
          ev_cnt   <= '0;
          n_q      <= (mode_eff == MODE_ONESHOT) ? BURST_W'(1) : burst_count;
        end else if (state == ST_RUN) begin
          if (sync_rise) begin
            pre_cnt <= '0;
            per_cnt <= '0;
          end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
            if (ev) begin
              per_cnt  <= '0;
              period_q <= user_period;
              ev_cnt   <= ev_cnt + BURST_W'(1);
            end else if (tick) begin
              per_cnt <= per_cnt + PERIOD_W'(1);
            end
          end
        end
        if (|ch_drop) overrun <= 1'b1;
      end
      if (ev) start_count <= start_count + START_CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    start_pulse_channel #(.DLY_W(DLY_W), .PW_W(PW_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .fire  (ev),
      .delay (ch_delay[i*DLY_W +: DLY_W]),
      .width (pulse_width),
      .out   (out_start[i]),
      .busy  (ch_busy[i]),
      .drop  (ch_drop[i])
    );
  end

  assign busy = (state != ST_IDLE) || (ch_busy != '0);
endmodule

// File: tb/tb_start_pulse_gen.sv
// Bench for start_pulse_gen with PRESCALE_W=2 (one tick = 4 clk); directed table, corner sequences, random vs event-time model.
module tb_start_pulse_gen;
  localparam int TMAX = 100;
  localparam int NV   = 7;

  logic        clk = 1'b0;
  logic        rst_n, enable, arm;
  logic [1:0]  mode;
  logic [7:0]  user_period, burst_count;
  logic [3:0]  pulse_width;
  logic [31:0] ch_delay;
  logic [3:0]  out_start;
  logic        busy, overrun;
  logic [15:0] start_count;
`ifdef START_GEN_EXT_SYNC_EN
  logic        ext_sync = 1'b0;
`endif

  always #5 clk = ~clk;

  start_pulse_gen #(.PRESCALE_W(2), .PERIOD_W(8), .NUM_CH(4), .DLY_W(8), .PW_W(4), .BURST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .arm(arm),
    .user_period(user_period), .burst_count(burst_count), .pulse_width(pulse_width),
    .ch_delay(ch_delay),
`ifdef START_GEN_EXT_SYNC_EN
    .ext_sync(ext_sync),
`endif
    .out_start(out_start), .busy(busy), .overrun(overrun), .start_count(start_count)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  per;
    logic [7:0]  n;
    logic [3:0]  w;
    logic [31:0] d;     // {ch3,ch2,ch1,ch0}
    logic [31:0] rise;  // first rising edge per channel, 0 = never
    logic [7:0]  ev;
    logic        ovr;
    logic        bsy;
  } vec_t;

  vec_t        tbl [NV];
  int          errors = 0, checks = 0;
  int          ref_count = 0;
  int          first_r [4];
  int          rises, busy_low;
  logic [3:0]  prev;
  logic [3:0]  m_out  [0:TMAX];
  bit          m_busy [0:TMAX];
  bit          m_ovr  [0:TMAX];
  int          m_cnt  [0:TMAX];
  int          m_dl   [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt_edge();
    @(negedge clk);
  endtask

  task automatic idle_gap();
    enable = 1'b0; arm = 1'b0;
    nxt_edge(); nxt_edge();
  endtask

  // Returns after edge 1 (the edge that samples enable=1 / arm).
  task automatic launch(input logic [1:0] m, input logic [7:0] p, input logic [7:0] n,
                        input logic [3:0] w, input logic [31:0] d);
    mode = m; user_period = p; burst_count = n; pulse_width = w; ch_delay = d;
    enable = 1'b1; arm = 1'b1;
    nxt_edge();
    arm = 1'b0;
  endtask

  // Event-time model: events at multiples of P*4 edges after edge 0; channel accepts if idle.
  task automatic build_model(input int md, input int p, input int n, input int w);
    int weff, nev, cyc, e, st, en, max_end, last_ev, first_drop, cnt;
    int free_t [4];
    bit launched;
    weff = (w == 0) ? 1 : w;
    launched = (md == 0) || (md == 2) || (md == 1 && n != 0);
    nev = (md == 0) ? 1000000 : ((md == 2) ? 1 : n);
    cyc = p * 4;
    for (int t = 0; t <= TMAX; t++) begin
      m_out[t] = '0; m_busy[t] = 1'b0; m_ovr[t] = 1'b0; m_cnt[t] = 0;
    end
    for (int c = 0; c < 4; c++) free_t[c] = 0;
    max_end = 0; last_ev = 0; first_drop = TMAX + 1;
    if (launched && cyc > 0) begin
      for (int m = 1; m <= nev && m * cyc <= TMAX; m++) begin
        e = m * cyc;
        last_ev = e;
        m_cnt[e] = 1;
        for (int c = 0; c < 4; c++) begin
          if (e >= free_t[c]) begin
            st = e + m_dl[c];
            en = st + weff - 1;
            for (int t = st; t <= en && t <= TMAX; t++) m_out[t][c] = 1'b1;
            free_t[c] = en + 2;
            if (en > max_end) max_end = en;
          end else if (e < first_drop) begin
            first_drop = e;
          end
        end
      end
    end
    cnt = 0;
    for (int t = 1; t <= TMAX; t++) begin
      cnt += m_cnt[t];
      m_cnt[t]  = cnt;
      m_ovr[t]  = (t >= first_drop);
      m_busy[t] = launched && ((md == 0) || (t <= last_ev) || (t <= max_end + 1));
    end
  endtask

  initial begin
    tbl[0] = '{mode:2'd0, per:8'd3, n:8'd0, w:4'd1, d:{8'd0,8'd0,8'd0,8'd0},
               rise:{8'd12,8'd12,8'd12,8'd12}, ev:8'd3, ovr:1'b0, bsy:1'b1};
    tbl[1] = '{mode:2'd1, per:8'd2, n:8'd3, w:4'd1, d:{8'd3,8'd2,8'd1,8'd0},
               rise:{8'd11,8'd10,8'd9,8'd8}, ev:8'd3, ovr:1'b0, bsy:1'b0};
    tbl[2] = '{mode:2'd2, per:8'd2, n:8'd5, w:4'd2, d:{8'd0,8'd0,8'd0,8'd5},
               rise:{8'd8,8'd8,8'd8,8'd13}, ev:8'd1, ovr:1'b0, bsy:1'b0};
    tbl[3] = '{mode:2'd0, per:8'd1, n:8'd0, w:4'd6, d:{8'd0,8'd0,8'd0,8'd0},
               rise:{8'd4,8'd4,8'd4,8'd4}, ev:8'd10, ovr:1'b1, bsy:1'b1};
    tbl[4] = '{mode:2'd1, per:8'd2, n:8'd0, w:4'd1, d:{8'd0,8'd0,8'd0,8'd0},
               rise:32'd0, ev:8'd0, ovr:1'b0, bsy:1'b0};
    tbl[5] = '{mode:2'd3, per:8'd1, n:8'd3, w:4'd1, d:{8'd0,8'd0,8'd0,8'd0},
               rise:32'd0, ev:8'd0, ovr:1'b0, bsy:1'b0};
    tbl[6] = '{mode:2'd1, per:8'd1, n:8'd2, w:4'd0, d:{8'd0,8'd7,8'd0,8'd0},
               rise:{8'd4,8'd11,8'd4,8'd4}, ev:8'd2, ovr:1'b1, bsy:1'b0};

    rst_n = 1'b0; enable = 1'b0; arm = 1'b0; mode = 2'd0;
    user_period = '0; burst_count = '0; pulse_width = '0; ch_delay = '0;
    nxt_edge(); nxt_edge();
    chk("reset_out", out_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_cnt", start_count, 0);
    rst_n = 1'b1;

    // Directed table, 40-edge window each.
    for (int v = 0; v < NV; v++) begin
      idle_gap();
      launch(tbl[v].mode, tbl[v].per, tbl[v].n, tbl[v].w, tbl[v].d);
      prev = '0;
      for (int c = 0; c < 4; c++) first_r[c] = 0;
      for (int k = 1; k <= 40; k++) begin
        for (int c = 0; c < 4; c++)
          if (out_start[c] && !prev[c] && first_r[c] == 0) first_r[c] = k;
        prev = out_start;
        if (k < 40) nxt_edge();
      end
      for (int c = 0; c < 4; c++) chk($sformatf("tbl%0d_rise_ch%0d", v, c), first_r[c], tbl[v].rise[c*8 +: 8]);
      ref_count += tbl[v].ev;
      chk($sformatf("tbl%0d_count", v), start_count, ref_count[15:0]);
      chk($sformatf("tbl%0d_ovr", v), overrun, tbl[v].ovr);
      chk($sformatf("tbl%0d_busy", v), busy, tbl[v].bsy);
    end

    // Enable dropped mid-pulse after an overrun.
    idle_gap();
    launch(2'd0, 8'd1, 8'd0, 4'd6, 32'd0);
    for (int k = 2; k <= 8; k++) nxt_edge();
    chk("abort_pre_out", out_start, 4'hF);
    chk("abort_pre_ovr", overrun, 1);
    enable = 1'b0;
    nxt_edge();
    ref_count += 2;
    chk("abort_out", out_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovr", overrun, 0);
    chk("abort_cnt", start_count, ref_count[15:0]);

    // P=0 periodic: no events, busy held, arm ignored.
    idle_gap();
    launch(2'd0, 8'd0, 8'd3, 4'd1, 32'd0);
    rises = 0; busy_low = 0; prev = out_start;
    for (int k = 2; k <= 1000; k++) begin
      nxt_edge();
      if (!busy) busy_low++;
      if (out_start != '0) rises++;
      arm = (k == 500);
    end
    arm = 1'b0;
    chk("p0_pulses", rises, 0);
    chk("p0_busy_low", busy_low, 0);
    chk("p0_cnt", start_count, ref_count[15:0]);

    // Burst with arm and mode change during the run: both ignored.
    idle_gap();
    launch(2'd1, 8'd2, 8'd2, 4'd1, 32'd0);
    rises = 0; prev = out_start;
    for (int k = 2; k <= 40; k++) begin
      arm  = (k == 11);
      if (k == 11) mode = 2'd0;
      nxt_edge();
      if (out_start[0] && !prev[0]) rises++;
      prev = out_start;
    end
    arm = 1'b0;
    ref_count += 2;
    chk("burst_arm_rises", rises, 2);
    chk("burst_arm_busy", busy, 0);
    chk("burst_arm_cnt", start_count, ref_count[15:0]);

`ifdef START_GEN_EXT_SYNC_EN
    // Sync edge sampled at edge 11 suppresses the event due at 16; next rise at 19.
    idle_gap();
    launch(2'd0, 8'd2, 8'd0, 4'd1, 32'd0);
    for (int c = 0; c < 2; c++) first_r[c] = 0;
    prev = out_start;
    for (int k = 2; k <= 22; k++) begin
      ext_sync = (k == 11);
      nxt_edge();
      if (out_start[0] && !prev[0]) begin
        if (first_r[0] == 0) first_r[0] = k;
        else if (first_r[1] == 0) first_r[1] = k;
      end
      prev = out_start;
    end
    ext_sync = 1'b0;
    ref_count += 2;
    chk("sync_first_rise", first_r[0], 8);
    chk("sync_second_rise", first_r[1], 19);
    chk("sync_cnt", start_count, ref_count[15:0]);
`endif

    // Randomized scenarios against the event-time model.
    for (int s = 0; s < 16; s++) begin
      int md, p, n, w;
      logic [31:0] dp;
      md = $urandom_range(0, 2);
      p  = $urandom_range(1, 4);
      n  = $urandom_range(0, 4);
      w  = $urandom_range(0, 7);
      for (int c = 0; c < 4; c++) begin
        m_dl[c] = $urandom_range(0, 9);
        dp[c*8 +: 8] = m_dl[c][7:0];
      end
      build_model(md, p, n, w);
      idle_gap();
      launch(md[1:0], p[7:0], n[7:0], w[3:0], dp);
      for (int k = 1; k <= TMAX; k++) begin
        chk($sformatf("rnd%0d_out@%0d", s, k), out_start, m_out[k]);
        chk($sformatf("rnd%0d_busy@%0d", s, k), busy, m_busy[k]);
        chk($sformatf("rnd%0d_ovr@%0d", s, k), overrun, m_ovr[k]);
        chk($sformatf("rnd%0d_cnt@%0d", s, k), start_count, 16'(ref_count + m_cnt[k]));
        if (k < TMAX) nxt_edge();
      end
      ref_count += m_cnt[TMAX];
      enable = 1'b0;
      nxt_edge();
      chk($sformatf("rnd%0d_off_out", s), out_start, 0);
      chk($sformatf("rnd%0d_off_busy", s), busy, 0);
      chk($sformatf("rnd%0d_off_ovr", s), overrun, 0);
      chk($sformatf("rnd%0d_off_cnt", s), start_count, ref_count[15:0]);
    end

    // Reset together with enable falling clears the event counter.
    launch(2'd0, 8'd1, 8'd0, 4'd1, 32'd0);
    for (int k = 2; k <= 6; k++) nxt_edge();
    rst_n = 1'b0; enable = 1'b0;
    nxt_edge();
    chk("final_reset_cnt", start_count, 0);
    chk("final_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
